serial_adder_ctrl: RTL and testbench

- Sequences a single 1-bit full-adder slice over WIDTH cycles, adding or subtracting two WIDTH-bit operands LSB-first.
- Holds the operand shift registers, the carry flip-flop, the bit counter and the start/busy/done handshake.
- Sits between a requesting datapath block and the existing 1-bit full-adder cell, which it instantiates once.
- Trades latency for area against a ripple adder of WIDTH cells.

---
 rtl/serial_adder_ctrl.sv | 190 +++++++++++++++++++
 tb/tb_serial_adder_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/serial_adder_ctrl.sv
// Serial add/subtract controller.
// Drives one 1-bit full-adder slice over WIDTH clock cycles, LSB first,
// to produce a WIDTH-bit sum/difference with carry-out and two's-complement
// overflow. The result registers change only when an operation completes,
// so a reader never observes a partially built result.

// ---------------------------------------------------------------------------
// 1-bit full-adder cell (the shared slice the controller sequences)
// ---------------------------------------------------------------------------
module full_adder_cell (
   input  logic x_i,
   input  logic y_i,
   input  logic c_i,
   output logic s_o,
   output logic c_o
);

   // Sum and carry of three 1-bit inputs
   always_comb begin
      s_o = x_i ^ y_i ^ c_i;
      c_o = (x_i & y_i) | (c_i & (x_i ^ y_i));
   end

endmodule : full_adder_cell

// ---------------------------------------------------------------------------
// Controller
// ---------------------------------------------------------------------------
module serial_adder_ctrl #(
   parameter int unsigned WIDTH = 8   // legal range 2..32
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic             sub,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             c_in,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] sum,
   output logic             c_out,
   output logic             overflow
);

   localparam int unsigned     CNT_W    = $clog2(WIDTH);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

   // 2'b11 is never entered; the default branch sends it back to IDLE.
   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_RUN  = 2'b01,
      ST_DONE = 2'b10
   } state_e;

   // ------------------------------------------------------------------
   // State and datapath registers
   // ------------------------------------------------------------------
   state_e           state_q,  state_d;
   logic [WIDTH-1:0] op_a_q,   op_a_d;     // operand A, shifts right
   logic [WIDTH-1:0] op_b_q,   op_b_d;     // operand B (or ~B), shifts right
   logic [WIDTH-2:0] res_q,    res_d;      // low result bits built so far
   logic             carry_q,  carry_d;    // carry into the current bit
   logic [CNT_W-1:0] cnt_q,    cnt_d;      // index of the bit being processed

   // Registered outputs
   logic             busy_q,   busy_d;
   logic             done_q,   done_d;
   logic [WIDTH-1:0] sum_q,    sum_d;
   logic             c_out_q,  c_out_d;
   logic             ovf_q,    ovf_d;

   // ------------------------------------------------------------------
   // Slice connection
   // ------------------------------------------------------------------
   logic             slice_s;
   logic             slice_c;
   logic [WIDTH-1:0] res_full;             // result including this cycle's bit

   full_adder_cell u_slice (
      .x_i (op_a_q[0]),
      .y_i (op_b_q[0]),
      .c_i (carry_q),
      .s_o (slice_s),
      .c_o (slice_c)
   );

   assign res_full = {slice_s, res_q};

   // ------------------------------------------------------------------
   // Next-state logic: operation acceptance, bit sequencing, completion
   // ------------------------------------------------------------------
   always_comb begin
      // NOTE: every _d starts from its _q so no path leaves a signal
      // unassigned; an unassigned path in always_comb infers a latch.
      state_d = state_q;
      op_a_d  = op_a_q;
      op_b_d  = op_b_q;
      res_d   = res_q;
      carry_d = carry_q;
      cnt_d   = cnt_q;
      busy_d  = busy_q;
      done_d  = done_q;
      sum_d   = sum_q;
      c_out_d = c_out_q;
      ovf_d   = ovf_q;

      case (state_q)
         ST_IDLE, ST_DONE: begin
            done_d = 1'b0;
            if (start) begin
               // Subtraction is a + ~b + 1, so the carry FF supplies the +1
               state_d = ST_RUN;
               busy_d  = 1'b1;
               op_a_d  = a;
               op_b_d  = sub ? ~b : b;
               carry_d = sub ? 1'b1 : c_in;
               cnt_d   = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_RUN: begin
            // One bit per cycle; start is deliberately ignored here
            op_a_d  = {1'b0, op_a_q[WIDTH-1:1]};
            op_b_d  = {1'b0, op_b_q[WIDTH-1:1]};
            res_d   = res_full[WIDTH-1:1];
            carry_d = slice_c;
            cnt_d   = cnt_q + 1'b1;
            if (cnt_q == LAST_BIT) begin
               // carry_q is the carry into the MSB at this point
               state_d = ST_DONE;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               sum_d   = res_full;
               c_out_d = slice_c;
               ovf_d   = carry_q ^ slice_c;
               cnt_d   = '0;
            end
         end

         default: begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b0;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // State register with asynchronous active-low reset
   // ------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: non-blocking assignments keep every flop sampling the values
      // from before the edge, independent of statement order.
      if (!rst_n) begin
         state_q <= ST_IDLE;
         op_a_q  <= '0;
         op_b_q  <= '0;
         res_q   <= '0;
         carry_q <= 1'b0;
         cnt_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         sum_q   <= '0;
         c_out_q <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
         res_q   <= res_d;
         carry_q <= carry_d;
         cnt_q   <= cnt_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         sum_q   <= sum_d;
         c_out_q <= c_out_d;
         ovf_q   <= ovf_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign sum      = sum_q;
   assign c_out    = c_out_q;
   assign overflow = ovf_q;

endmodule : serial_adder_ctrl

// File: tb/tb_serial_adder_ctrl.sv
// Self-checking bench for serial_adder_ctrl (WIDTH = 8).
// Expected results come from plain integer arithmetic on the operands.
module tb_serial_adder_ctrl;

   localparam int unsigned W = 8;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         start;
   logic         sub;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic         c_in;
   logic         busy;
   logic         done;
   logic [W-1:0] sum;
   logic         c_out;
   logic         overflow;

   int checks = 0;
   int errors = 0;

   // Expected result of the operation in flight, and last completed result
   logic [W-1:0] exp_sum;
   logic         exp_c;
   logic         exp_v;
   logic [W-1:0] hold_sum = '0;
   logic         hold_c   = 1'b0;
   logic         hold_v   = 1'b0;

   serial_adder_ctrl #(.WIDTH(W)) dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .sub      (sub),
      .a        (a),
      .b        (b),
      .c_in     (c_in),
      .busy     (busy),
      .done     (done),
      .sum      (sum),
      .c_out    (c_out),
      .overflow (overflow)
   );

   always #5 clk = ~clk;

   // Safety net: the run must always end by itself
   initial begin
      #200000;
      $display("FAIL timeout: run did not reach its summary line");
      $fatal(1, "timeout");
   end

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference: integer add of a, effective b and carry-in
   task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                        input logic mcin, input logic msub);
      int unsigned bv;
      int unsigned ci;
      int unsigned total;
      bv      = msub ? ((2**W - 1) - int'(mb)) : int'(mb);
      ci      = msub ? 1 : int'(mcin);
      total   = int'(ma) + bv + ci;
      exp_sum = W'(total % (2**W));
      exp_c   = (total >= 2**W);
      // Signed overflow: operands share a sign the result does not
      exp_v   = (ma[W-1] == bv[W-1]) && (exp_sum[W-1] != ma[W-1]);
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic [W-1:0] da, input logic [W-1:0] db,
                        input logic dcin, input logic dsub);
      a    = da;
      b    = db;
      c_in = dcin;
      sub  = dsub;
   endtask

   task automatic scramble_inputs;
      drive(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
   endtask

   task automatic expect_running(input string tag);
      check({tag, "_busy"},  64'(busy),     64'(1));
      check({tag, "_done"},  64'(done),     64'(0));
      check({tag, "_hold"},  64'(sum),      64'(hold_sum));
      check({tag, "_holdc"}, 64'(c_out),    64'(hold_c));
      check({tag, "_holdv"}, 64'(overflow), 64'(hold_v));
   endtask

   task automatic expect_done(input string tag);
      check({tag, "_dbusy"}, 64'(busy),     64'(0));
      check({tag, "_done"},  64'(done),     64'(1));
      check({tag, "_sum"},   64'(sum),      64'(exp_sum));
      check({tag, "_cout"},  64'(c_out),    64'(exp_c));
      check({tag, "_ovf"},   64'(overflow), 64'(exp_v));
      hold_sum = exp_sum;
      hold_c   = exp_c;
      hold_v   = exp_v;
   endtask

   // One isolated operation; poke=1 pulses start before edge k+3
   task automatic run_op(input string tag, input logic [W-1:0] oa, input logic [W-1:0] ob,
                         input logic ocin, input logic osub, input bit poke);
      model(oa, ob, ocin, osub);
      drive(oa, ob, ocin, osub);
      start = 1'b1;
      tick();                                  // accepting edge k
      start = 1'b0;
      scramble_inputs();
      expect_running(tag);
      for (int i = 1; i < W; i++) begin
         if (poke && i == 3) begin
            drive(~oa, oa ^ ob, ~ocin, ~osub);
            start = 1'b1;
         end
         tick();
         start = 1'b0;
         expect_running(tag);
      end
      tick();                                  // edge k+W
      expect_done(tag);
      tick();
      check({tag, "_pdone"}, 64'(done), 64'(0));
      check({tag, "_pbusy"}, 64'(busy), 64'(0));
      check({tag, "_psum"},  64'(sum),  64'(hold_sum));
   endtask

   logic [W-1:0] bb_a [3];
   logic [W-1:0] bb_b [3];
   logic         bb_c [3];
   logic         bb_s [3];

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      drive('0, '0, 1'b0, 1'b0);
      #12;
      check("rst_busy", 64'(busy),     64'(0));
      check("rst_done", 64'(done),     64'(0));
      check("rst_sum",  64'(sum),      64'(0));
      check("rst_cout", 64'(c_out),    64'(0));
      check("rst_ovf",  64'(overflow), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      check("idle_busy", 64'(busy), 64'(0));

      // Directed cases
      run_op("add5a3c",  8'h5A, 8'h3C, 1'b0, 1'b0, 1'b0);
      run_op("addff01",  8'hFF, 8'h01, 1'b0, 1'b0, 1'b0);
      run_op("add7fci",  8'h7F, 8'h00, 1'b1, 1'b0, 1'b0);
      run_op("sub1020",  8'h10, 8'h20, 1'b1, 1'b1, 1'b0);
      run_op("sub8001",  8'h80, 8'h01, 1'b0, 1'b1, 1'b0);
      run_op("poke",     8'h33, 8'h44, 1'b1, 1'b0, 1'b1);

      // Reset in the middle of a run
      drive(8'hC3, 8'h5E, 1'b1, 1'b0);
      start = 1'b1;
      tick();
      start = 1'b0;
      tick();
      tick();
      tick();
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("abort_busy", 64'(busy),     64'(0));
      check("abort_done", 64'(done),     64'(0));
      check("abort_sum",  64'(sum),      64'(0));
      check("abort_cout", 64'(c_out),    64'(0));
      check("abort_ovf",  64'(overflow), 64'(0));
      hold_sum = '0;
      hold_c   = 1'b0;
      hold_v   = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < W + 2; i++) begin
         tick();
         check("abort_nodone", 64'(done), 64'(0));
         check("abort_idle",   64'(busy), 64'(0));
      end
      run_op("post_rst", 8'h81, 8'h7F, 1'b0, 1'b0, 1'b0);

      // Back-to-back: start held high for three operations
      bb_a = '{8'h12, 8'hF0, 8'h80};
      bb_b = '{8'h34, 8'h0F, 8'h7F};
      bb_c = '{1'b1,  1'b0,  1'b0};
      bb_s = '{1'b0,  1'b1,  1'b1};
      drive(bb_a[0], bb_b[0], bb_c[0], bb_s[0]);
      start = 1'b1;
      for (int j = 0; j < 3; j++) begin
         model(bb_a[j], bb_b[j], bb_c[j], bb_s[j]);
         tick();                               // accepting edge
         if (j < 2) drive(bb_a[j+1], bb_b[j+1], bb_c[j+1], bb_s[j+1]);
         else       start = 1'b0;
         expect_running("b2b");
         for (int i = 1; i < W; i++) begin
            tick();
            expect_running("b2b");
         end
         tick();
         expect_done("b2b");
      end
      tick();
      check("b2b_end_done", 64'(done), 64'(0));
      check("b2b_end_busy", 64'(busy), 64'(0));
      check("b2b_end_sum",  64'(sum),  64'(hold_sum));

      // Randomized operations
      for (int n = 0; n < 24; n++) begin
         run_op("rand", W'($urandom), W'($urandom), 1'($urandom), 1'($urandom),
                1'($urandom_range(0, 3) == 0));
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_serial_adder_ctrl
